fir_stream_ctrl: RTL and testbench
==================================

// Module: fir_stream_ctrl
// PURPOSE
//  Host-side driver for the 8-tap FIR datapath. Holds the other end of the datapath's coeff-write and shift ports.
//  Converts a valid/ready coefficient stream into addressed coefficient writes.
//  Converts a valid/ready sample stream into shift pulses, and the 32-bit sum into a valid/ready result stream.
//  Sits between the system stream fabric and the datapath; one instance per filter.
// PARAMETERS
//  NTAPS    8   taps; coefficient address width = $clog2(NTAPS)=3
//  COEFF_W  8   coefficient width (signed)
//  DATA_W   8   sample width (signed)
//  ACC_W    32  datapath sum / result width
// PORTS
//  clk               in   1        system clock, all logic on posedge
//  rst               in   1        synchronous reset, active-high
//  i_cfg_start       in   1        request (re)load of all NTAPS coefficients
//  i_cfg_valid       in   1        coefficient beat valid (tap 0 first)
//  i_cfg_data        in   COEFF_W  coefficient beat
//  o_cfg_ready       out  1        coefficient beat accepted when valid&ready
//  i_s_valid         in   1        input sample valid
//  i_s_data          in   DATA_W   input sample
//  o_s_ready         out  1        sample accepted when valid&ready
//  o_m_valid         out  1        result valid
//  o_m_data          out  ACC_W    result (signed FIR sum)
//  i_m_ready         in   1        result consumer ready
//  o_coeff_write_en  out  1        to datapath coefficient write enable
//  o_coeff_addr      out  3        to datapath coefficient address
//  o_coeff_data      out  COEFF_W  to datapath coefficient data
//  o_shift_enable    out  1        to datapath shift enable
//  o_data            out  DATA_W   to datapath sample input
//  i_fir_data        in   ACC_W    from datapath sum (combinational off its registers)
//  o_loaded          out  1        full coefficient set written since last start
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, cnt=0, pend=0, o_m_valid=0, o_m_data=0, o_loaded=0.
//   All datapath-side strobes are 0 while in IDLE. The datapath has its own reset; this block never clears it.
//  FSM IDLE/LOAD/RUN (+FLUSH, see CONFIGURATION).
//  start_ok = i_cfg_start & !pend & !o_m_valid in IDLE/RUN. In LOAD, i_cfg_start always restarts: cnt=0.
//  start_ok -> LOAD, cnt=0, o_loaded=0.
//  LOAD: o_cfg_ready=1; o_coeff_write_en=i_cfg_valid; o_coeff_addr=cnt; o_coeff_data=i_cfg_data (combinational).
//   Each handshake increments cnt. The handshake at cnt=NTAPS-1 sets o_loaded=1 and moves to RUN.
//   i_cfg_start and i_cfg_valid in the same LOAD cycle: the write is suppressed, and the restart wins.
//  RUN: o_s_ready = !pend & (!o_m_valid | i_m_ready) & !i_cfg_start.
//   Handshake at edge T: o_shift_enable=1 and o_data=i_s_data during T (combinational); pend<=1.
//   Edge T+1: if out slot free (!o_m_valid or i_m_ready), o_m_data<=i_fir_data, o_m_valid<=1, pend<=0.
//   If the slot is not free, pend holds; no shift occurs, so i_fir_data is stable.
//  Max throughput 1 sample / 2 clk. Latency: accept edge T -> o_m_valid high after edge T+1.
//  o_m_valid drops on i_m_ready when no new capture occurs in the same cycle.
//  Capture and pop in the same cycle: the new value replaces the old one; o_m_valid stays 1.
//  o_coeff_write_en and o_shift_enable are never high together. o_data=0 when o_shift_enable=0.
//  Outside RUN: o_s_ready=0. Outside LOAD: o_cfg_ready=0.
//  i_cfg_start in RUN with pend|o_m_valid: ignored until drained. The requester must hold start.
//  Result is i_fir_data unmodified (full ACC_W, two's complement); no rounding or saturation.
// CONFIGURATION
//  FIR_CTRL_FLUSH_EN defined: the last LOAD handshake enters FLUSH instead of RUN.
//   FLUSH issues NTAPS consecutive shifts with o_data=0 (cnt counts 0..NTAPS-1), then enters RUN.
//   o_s_ready=0 and o_m_valid is not set during FLUSH. Results after a reload depend only on new samples.
//   i_cfg_start in FLUSH restarts LOAD.
//  FIR_CTRL_FLUSH_EN undefined: no FLUSH state; LOAD goes directly to RUN.
//   The delay line keeps the pre-reload samples.
// TESTING
//  1 rst=1 two cycles -> all outputs 0, o_s_ready=0, o_cfg_ready=0.
//  2 start, coeffs 1..8 with a 2-cycle valid gap after beat 3
//    -> exactly 8 write pulses, addr 0..7, data 1..8; o_loaded=1 after the 8th beat.
//  3 coeffs all 1, samples 1,0,0,...(12 beats), i_m_ready=1
//    -> results 1 x8, then 0; one result per accepted sample.
//  4 coeffs all 1, samples 5 and -3, i_m_ready=0 for 6 cycles
//    -> o_m_data=5 held, o_s_ready=0, no shift; after release, next result 2.
//  5 in RUN with o_m_valid=1, raise start -> ignored until pop.
//    Then reload all coeffs 2; impulse 4 -> results 8.
//  6 samples 7 x8, reload coeffs 1, then samples 0: FLUSH_EN -> first result 0; undefined -> first result 49.

Source files
------------

// File: rtl/fir_stream_ctrl_if.sv
// Stream and datapath bundle for fir_stream_ctrl.
// master = controller side, slave = fabric/datapath side.
interface fir_stream_ctrl_if #(
  parameter int NTAPS   = 8,
  parameter int COEFF_W = 8,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32
);
  localparam int AW = $clog2(NTAPS);

  logic               i_cfg_start;
  logic               i_cfg_valid;
  logic [COEFF_W-1:0] i_cfg_data;
  logic               o_cfg_ready;
  logic               i_s_valid;
  logic [DATA_W-1:0]  i_s_data;
  logic               o_s_ready;
  logic               o_m_valid;
  logic [ACC_W-1:0]   o_m_data;
  logic               i_m_ready;
  logic               o_coeff_write_en;
  logic [AW-1:0]      o_coeff_addr;
  logic [COEFF_W-1:0] o_coeff_data;
  logic               o_shift_enable;
  logic [DATA_W-1:0]  o_data;
  logic [ACC_W-1:0]   i_fir_data;
  logic               o_loaded;

  modport master (
    input  i_cfg_start, i_cfg_valid, i_cfg_data,
    output o_cfg_ready,
    input  i_s_valid, i_s_data,
    output o_s_ready,
    output o_m_valid, o_m_data,
    input  i_m_ready,
    output o_coeff_write_en, o_coeff_addr,
    output o_coeff_data,
    output o_shift_enable, o_data,
    input  i_fir_data,
    output o_loaded
  );

  modport slave (
    output i_cfg_start, i_cfg_valid, i_cfg_data,
    input  o_cfg_ready,
    output i_s_valid, i_s_data,
    input  o_s_ready,
    input  o_m_valid, o_m_data,
    output i_m_ready,
    input  o_coeff_write_en, o_coeff_addr,
    input  o_coeff_data,
    input  o_shift_enable, o_data,
    output i_fir_data,
    input  o_loaded
  );
endinterface

// File: rtl/fir_stream_ctrl.sv
// Stream-to-datapath controller for the 8-tap FIR.
// Optional FIR_CTRL_FLUSH_EN: zero the delay line after reload.
module fir_stream_ctrl #(
  parameter int NTAPS = 8,
  parameter int ACC_W = 32
) (
  input  logic clk,
  input  logic rst,
  fir_stream_ctrl_if.master bus
);
  localparam int AW = $clog2(NTAPS);

`ifdef FIR_CTRL_FLUSH_EN
  typedef enum logic [1:0] {
    IDLE, LOAD, RUN, FLUSH
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOAD, RUN
  } state_t;
`endif

  state_t           state;
  logic [AW-1:0]    cnt;
  logic             pend;
  logic             m_valid;
  logic [ACC_W-1:0] m_data;
  logic             loaded;

  logic in_load;
  logic in_run;
  logic in_flush;
  logic slot_free;
  logic s_ready;
  logic s_hs;
  logic cfg_hs;
  logic start_ok;
  logic last;
  logic flush_shift;

  assign in_load = (state == LOAD);
  assign in_run  = (state == RUN);
`ifdef FIR_CTRL_FLUSH_EN
  assign in_flush = (state == FLUSH);
`else
  assign in_flush = 1'b0;
`endif

  assign slot_free = !m_valid | bus.i_m_ready;
  assign s_ready   = in_run & !pend & slot_free
                   & !bus.i_cfg_start;
  assign s_hs      = s_ready & bus.i_s_valid;
  assign cfg_hs    = in_load & bus.i_cfg_valid
                   & !bus.i_cfg_start;
  assign start_ok  = bus.i_cfg_start & !pend & !m_valid
                   & ((state == IDLE) | in_run);
  assign last      = (cnt == AW'(NTAPS - 1));
  assign flush_shift = in_flush & !bus.i_cfg_start;

  assign bus.o_cfg_ready      = in_load;
  assign bus.o_coeff_write_en = cfg_hs;
  assign bus.o_coeff_addr     = in_load ? cnt : '0;
  assign bus.o_coeff_data     = in_load ? bus.i_cfg_data : '0;
  assign bus.o_s_ready        = s_ready;
  assign bus.o_shift_enable   = s_hs | flush_shift;
  assign bus.o_data           = s_hs ? bus.i_s_data : '0;
  assign bus.o_m_valid        = m_valid;
  assign bus.o_m_data         = m_data;
  assign bus.o_loaded         = loaded;

  // Control FSM, result slot and pending-capture tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      m_valid <= 1'b0;
      m_data  <= '0;
      loaded  <= 1'b0;
    end else begin
      if (m_valid & bus.i_m_ready)
        m_valid <= 1'b0;
      if (pend & slot_free) begin
        m_data  <= bus.i_fir_data;
        m_valid <= 1'b1;
        pend    <= 1'b0;
      end
      if (s_hs)
        pend <= 1'b1;

      unique case (state)
        IDLE, RUN: begin
          if (start_ok) begin
            state  <= LOAD;
            cnt    <= '0;
            loaded <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.i_cfg_start) begin
            cnt <= '0;
          end else if (cfg_hs) begin
            if (last) begin
              cnt    <= '0;
              loaded <= 1'b1;
`ifdef FIR_CTRL_FLUSH_EN
              state  <= FLUSH;
`else
              state  <= RUN;
`endif
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
`ifdef FIR_CTRL_FLUSH_EN
        FLUSH: begin
          if (bus.i_cfg_start) begin
            state  <= LOAD;
            cnt    <= '0;
            loaded <= 1'b0;
          end else if (last) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// Directed bench for fir_stream_ctrl with a datapath
// stand-in and a sample-history reference model.
module tb_fir_stream_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_stream_ctrl_if bus ();

  fir_stream_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  // datapath stand-in: tap 0 holds the newest sample
  logic signed [7:0]  dc [8];
  logic signed [7:0]  dt [8];
  logic signed [31:0] dp_sum;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        dc[k] <= '0;
        dt[k] <= '0;
      end
    end else begin
      if (bus.o_coeff_write_en)
        dc[bus.o_coeff_addr] <= bus.o_coeff_data;
      if (bus.o_shift_enable) begin
        dt[0] <= bus.o_data;
        for (int k = 1; k < 8; k++)
          dt[k] <= dt[k-1];
      end
    end
  end

  always_comb begin
    dp_sum = '0;
    for (int k = 0; k < 8; k++)
      dp_sum = dp_sum + 32'(dc[k]) * 32'(dt[k]);
  end
  assign bus.i_fir_data = dp_sum;

  // reference model: full sample history + coeff set
  int msamp [$];
  int mc [8];
  int exp_q [$];
  int got_q [$];
  int waddr [$];
  int wdata [$];
  int acc_cnt = 0;
  bit lat_chk = 1'b0;
  bit acc_d1 = 1'b0;
  bit acc_d2 = 1'b0;

  function automatic int model_out();
    int s = 0;
    int n = msamp.size();
    for (int k = 0; k < 8; k++)
      if (n > k) s += mc[k] * msamp[n-1-k];
    return s;
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    bit acc;
    if (!rst) begin
      chk("we_shift_excl",
          bus.o_coeff_write_en & bus.o_shift_enable, 0);
      if (!bus.o_shift_enable)
        chk("data_idle", $signed(bus.o_data), 0);
      if (bus.o_coeff_write_en) begin
        waddr.push_back(int'(bus.o_coeff_addr));
        wdata.push_back(int'($signed(bus.o_coeff_data)));
      end
      acc = bus.i_s_valid & bus.o_s_ready;
      if (acc) begin
        msamp.push_back(int'($signed(bus.i_s_data)));
        exp_q.push_back(model_out());
        acc_cnt++;
      end
      if (bus.o_m_valid & bus.i_m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("result", $signed(bus.o_m_data),
              exp_q.pop_front());
          got_q.push_back(int'($signed(bus.o_m_data)));
        end
      end
      if (lat_chk)
        chk("latency", bus.o_m_valid, acc_d2);
      acc_d2 = acc_d1;
      acc_d1 = acc;
    end
  end

  task automatic wait_cfg_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.o_cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_cfg_ready)
      chk("cfg_ready_timeout", 0, 1);
  endtask

  task automatic wait_s_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.o_s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_s_ready)
      chk("s_ready_timeout", 0, 1);
  endtask

  task automatic load(input int c [8],
                      input int gap_after);
    waddr.delete();
    wdata.delete();
    bus.i_cfg_start = 1'b1;
    wait_cfg_ready();
    @(posedge clk); #1;
    bus.i_cfg_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.i_cfg_valid = 1'b1;
      bus.i_cfg_data  = 8'(c[i]);
      wait_cfg_ready();
      if (i == 7)
        chk("loaded_before_last", bus.o_loaded, 0);
      @(posedge clk); #1;
      bus.i_cfg_valid = 1'b0;
      bus.i_cfg_data  = '0;
      if (i == gap_after) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    chk("loaded", bus.o_loaded, 1);
    chk("write_count", waddr.size(), 8);
    for (int i = 0; i < 8 && i < waddr.size(); i++) begin
      chk("write_addr", waddr[i], i);
      chk("write_data", wdata[i], c[i]);
    end
    mc = c;
`ifdef FIR_CTRL_FLUSH_EN
    repeat (8) msamp.push_back(0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic send(input int s);
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = 8'(s);
    wait_s_ready();
    @(posedge clk); #1;
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0)
      chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c18 [8];
    int ones [8];
    int twos [8];
    int lit3 [12];
    lit3 = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      c18[i]  = i + 1;
      ones[i] = 1;
      twos[i] = 2;
    end

    rst             = 1'b1;
    bus.i_cfg_start = 1'b0;
    bus.i_cfg_valid = 1'b0;
    bus.i_cfg_data  = '0;
    bus.i_s_valid   = 1'b0;
    bus.i_s_data    = '0;
    bus.i_m_ready   = 1'b0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", bus.o_m_valid, 0);
    chk("rst_m_data", bus.o_m_data, 0);
    chk("rst_loaded", bus.o_loaded, 0);
    chk("rst_s_ready", bus.o_s_ready, 0);
    chk("rst_cfg_ready", bus.o_cfg_ready, 0);
    chk("rst_we", bus.o_coeff_write_en, 0);
    chk("rst_shift", bus.o_shift_enable, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_addr", bus.o_coeff_addr, 0);
    chk("rst_cdata", bus.o_coeff_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // coeffs 1..8 with a gap after beat 3
    load(c18, 2);

    // impulse response with all-ones coeffs
    bus.i_m_ready = 1'b1;
    load(ones, -1);
    got_q.delete();
    acc_cnt = 0;
    lat_chk = 1'b1;
    send(1);
    repeat (11) send(0);
    drain();
    repeat (4) @(posedge clk);
    #1;
    lat_chk = 1'b0;
    chk("t3_count", got_q.size(), 12);
    chk("t3_accepted", acc_cnt, 12);
    for (int i = 0; i < 12 && i < got_q.size(); i++)
      chk("t3_lit", got_q[i], lit3[i]);

    // backpressure holds the result slot
    got_q.delete();
    bus.i_m_ready = 1'b0;
    send(5);
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = 8'(-3);
    @(negedge clk);
    repeat (6) begin
      @(negedge clk);
      chk("t4_s_ready", bus.o_s_ready, 0);
      chk("t4_shift", bus.o_shift_enable, 0);
      chk("t4_m_valid", bus.o_m_valid, 1);
      chk("t4_hold", $signed(bus.o_m_data), 5);
    end
    @(posedge clk); #1;
    bus.i_m_ready = 1'b1;
    wait_s_ready();
    @(posedge clk); #1;
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
    drain();
    chk("t4_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t4_first", got_q[0], 5);
      chk("t4_second", got_q[1], 2);
    end

    // start held off while a result is pending
    repeat (8) send(0);
    drain();
    bus.i_m_ready = 1'b0;
    send(0);
    @(negedge clk);
    @(posedge clk); #1;
    bus.i_cfg_start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_cfg_ready", bus.o_cfg_ready, 0);
      chk("t5_m_valid", bus.o_m_valid, 1);
      chk("t5_loaded", bus.o_loaded, 1);
      chk("t5_s_ready", bus.o_s_ready, 0);
    end
    @(posedge clk); #1;
    bus.i_m_ready = 1'b1;
    load(twos, -1);
    drain();
    got_q.delete();
    send(4);
    repeat (3) send(0);
    drain();
    chk("t5_count", got_q.size(), 4);
    for (int i = 0; i < got_q.size(); i++)
      chk("t5_lit", got_q[i], 8);

    // reload with or without delay-line flush
    repeat (8) send(7);
    drain();
    load(ones, -1);
    got_q.delete();
    send(0);
    drain();
    chk("t6_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
`ifdef FIR_CTRL_FLUSH_EN
      chk("t6_first", got_q[0], 0);
`else
      chk("t6_first", got_q[0], 49);
`endif
    end

    repeat (4) @(posedge clk);
    chk("leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
